// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - run/pause/clear/load sequencer for a 74163-style 4-bit counter
module counter_sequencer #(
    parameter int DIV = 25_000_000
) (
    input  logic       CLK50M,
    input  logic       RSTb,
    input  logic       RUN_BTN,
    input  logic       CLR_BTN,
    input  logic       LD_BTN,
    input  logic       ONESHOT,
    input  logic       RCO,
    output logic       ENP,
    output logic       ENT,
    output logic       LDb,
    output logic       CLRb,
    output logic       TICK,
    output logic       isHalf,
    output logic [1:0] STATE,
    output logic       DONE
);
    localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] TC   = PW'(DIV - 1);
    localparam logic [PW-1:0] HALF = PW'(DIV / 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    logic [2:0]    sync1_q, sync2_q, prev_q, ev_q;
    logic [1:0]    fill_q;
    logic          armed;
    logic          run_ev, clr_ev, ld_ev, terminal;
    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          enp_q, enp_d, ent_q, ent_d, ldb_q, ldb_d, clrb_q, clrb_d;
    logic          tick_q, tick_d, half_q, half_d, done_q, done_d;

    assign armed                   = (fill_q == 2'd3);
    assign {ld_ev, clr_ev, run_ev} = ev_q;
    assign terminal                = (state_q == S_RUN) && (presc_q == TC);

    // Edges only count once prev_q holds a genuine post-reset sample, so a
    // button held through reset release never fires.
    always_ff @(posedge CLK50M or negedge RSTb) begin
        if (!RSTb) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            prev_q  <= 3'b000;
            ev_q    <= 3'b000;
            fill_q  <= 2'd0;
        end else begin
            sync1_q <= {LD_BTN, CLR_BTN, RUN_BTN};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            ev_q    <= armed ? (sync2_q & ~prev_q) : 3'b000;
            if (!armed) begin
                fill_q <= fill_q + 2'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr_ev) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_PAUSE: if (!ld_ev && run_ev) state_d = S_RUN;
                S_RUN: begin
                    if (ONESHOT && RCO) begin
                        state_d = S_DONE;
                    end else if (!ld_ev && run_ev) begin
                        state_d = S_PAUSE;
                    end
                end
                S_DONE:  if (ld_ev) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // The prescaler advances on every RUN cycle, including the one that
    // pauses, so resume picks up one count past the pause point.
    always_comb begin
        presc_d = presc_q;
        if (clr_ev || state_d == S_IDLE || state_d == S_DONE) begin
            presc_d = '0;
        end else if (state_q == S_RUN) begin
            presc_d = terminal ? '0 : presc_q + PW'(1);
        end
        enp_d  = terminal && (state_d == S_RUN);
        tick_d = terminal && !clr_ev;
        ldb_d  = !(ld_ev && !clr_ev && (state_q != S_RUN));
        clrb_d = !clr_ev;
        ent_d  = (state_d == S_RUN) || (state_d == S_PAUSE);
        half_d = ent_d && (presc_d >= HALF);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge CLK50M or negedge RSTb) begin
        if (!RSTb) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            enp_q   <= 1'b0;
            ent_q   <= 1'b0;
            ldb_q   <= 1'b1;
            clrb_q  <= 1'b1;
            tick_q  <= 1'b0;
            half_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            enp_q   <= enp_d;
            ent_q   <= ent_d;
            ldb_q   <= ldb_d;
            clrb_q  <= clrb_d;
            tick_q  <= tick_d;
            half_q  <= half_d;
            done_q  <= done_d;
        end
    end

    assign ENP    = enp_q;
    assign ENT    = ent_q;
    assign LDb    = ldb_q;
    assign CLRb   = clrb_q;
    assign TICK   = tick_q;
    assign isHalf = half_q;
    assign STATE  = state_q;
    assign DONE   = done_q;
endmodule

// File: tb/tb_counter_sequencer.sv
// tb/tb_counter_sequencer.sv - self-checking bench for counter_sequencer
module tb_counter_sequencer;
    localparam int DIV = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    logic run_btn = 1'b0, clr_btn = 1'b0, ld_btn = 1'b0, oneshot = 1'b0, rco = 1'b0;
    logic enp, ent, ldb, clrb, tick_o, is_half, done_o;
    logic [1:0] state;
    int checks = 0, errors = 0;

    always #10 clk = ~clk;

    counter_sequencer #(.DIV(DIV)) dut (
        .CLK50M(clk), .RSTb(rst_n), .RUN_BTN(run_btn), .CLR_BTN(clr_btn),
        .LD_BTN(ld_btn), .ONESHOT(oneshot), .RCO(rco),
        .ENP(enp), .ENT(ent), .LDb(ldb), .CLRb(clrb), .TICK(tick_o),
        .isHalf(is_half), .STATE(state), .DONE(done_o)
    );

    // Reference model: 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE; phase is the tick position.
    int m_state, m_phase, m_nsamp;
    logic [2:0] m_last, m_pipe0, m_pipe1, m_pipe2;
    logic m_enp, m_ent, m_ldb, m_clrb, m_tick, m_half, m_done;

    task automatic m_reset();
        m_state = 0; m_phase = 0; m_nsamp = 0;
        m_last = 3'b000; m_pipe0 = 3'b000; m_pipe1 = 3'b000; m_pipe2 = 3'b000;
        m_enp = 0; m_ent = 0; m_ldb = 1; m_clrb = 1; m_tick = 0; m_half = 0; m_done = 0;
    endtask

    task automatic m_step();
        logic [2:0] cur, raw, act;
        cur = {ld_btn, clr_btn, run_btn};
        raw = (m_nsamp > 0) ? (cur & ~m_last) : 3'b000;
        m_last = cur;
        m_nsamp++;
        act = m_pipe2; m_pipe2 = m_pipe1; m_pipe1 = m_pipe0; m_pipe0 = raw;
        m_enp = 0; m_tick = 0; m_ldb = 1; m_clrb = 1;
        if (act[1]) begin
            m_clrb = 0; m_state = 0; m_phase = 0;
        end else begin
            case (m_state)
                0, 2: begin
                    if (act[2]) m_ldb = 0;
                    else if (act[0]) m_state = 1;
                end
                1: begin
                    m_tick = (m_phase == DIV - 1);
                    m_phase = (m_phase + 1) % DIV;
                    if (oneshot && rco) begin
                        m_state = 3; m_phase = 0;
                    end else if (act[0] && !act[2]) begin
                        m_state = 2;
                    end else begin
                        m_enp = m_tick;
                    end
                end
                default: begin
                    if (act[2]) begin m_ldb = 0; m_state = 0; end
                end
            endcase
        end
        m_ent = (m_state == 1) || (m_state == 2);
        m_done = (m_state == 3);
        m_half = m_ent && (m_phase >= DIV / 2);
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    initial begin
        logic [8:0] got, exp;
        forever begin
            @(negedge clk);
            got = {enp, ent, ldb, clrb, tick_o, is_half, state, done_o};
            exp = {m_enp, m_ent, m_ldb, m_clrb, m_tick, m_half, 2'(m_state), m_done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL model_cmp t=%0t dut=%b model=%b (enp ent ldb clrb tick half state done)",
                         $time, got, exp);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #2;
    endtask

    task automatic press(input logic [2:0] mask);
        {ld_btn, clr_btn, run_btn} = mask;
        tick(1);
        {ld_btn, clr_btn, run_btn} = 3'b000;
    endtask

    initial begin
        #100_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int tr, nenp;
        logic [1:0] prev;
        logic found;
        tick(3);
        chk("reset_vals", 32'({enp, ent, ldb, clrb, tick_o, is_half, state, done_o}), 32'h060);
        rst_n = 1'b1;
        tick(6);

        // Start and steady cadence
        press(3'b001);
        tick(2);
        chk("start_not_yet", 32'(state), 0);
        tick(1);
        chk("start_run", 32'(state), 1);
        chk("start_ent", 32'(ent), 1);
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            chk("cadence_enp", 32'(enp), (k % 4 == 0) ? 1 : 0);
            chk("cadence_tick", 32'(tick_o), (k % 4 == 0) ? 1 : 0);
            chk("cadence_half", 32'(is_half), (k % 4 >= 2) ? 1 : 0);
        end

        // Pause with prescaler at 2, hold, resume
        tick(3);
        press(3'b001);
        chk("step_before_pause", 32'(enp), 1);
        tick(3);
        chk("paused", 32'(state), 2);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("pause_hold", 32'({state, enp, is_half}), 32'b1001);
        end
        press(3'b001);
        tick(2);
        chk("resume_not_yet", 32'(state), 2);
        tick(1);
        chk("resume_run", 32'({state, enp}), 32'b010);
        tick(1);
        chk("resume_first_enp", 32'({enp, tick_o}), 32'b11);

        // Clear and load together while paused
        press(3'b001);
        tick(3);
        chk("prio_paused", 32'(state), 2);
        press(3'b110);
        tick(2);
        chk("prio_not_yet", 32'(clrb), 1);
        tick(1);
        chk("prio_clr", 32'({clrb, ldb, state, is_half, ent}), 32'b010000);
        tick(1);
        chk("prio_clr_one_cycle", 32'({clrb, ldb}), 32'b11);

        // One-shot stop at terminal count, then load back to IDLE
        oneshot = 1'b1;
        press(3'b001);
        tick(3);
        chk("os_run", 32'(state), 1);
        tick(3);
        rco = 1'b1;
        tick(1);
        rco = 1'b0;
        chk("os_done", 32'({enp, state, done_o, ent}), 32'b01110);
        press(3'b100);
        tick(2);
        chk("os_ld_not_yet", 32'(ldb), 1);
        tick(1);
        chk("os_ld", 32'({ldb, state, done_o}), 32'b0000);
        tick(1);
        chk("os_ld_one_cycle", 32'(ldb), 1);
        oneshot = 1'b0;

        // Held button, free-run with RCO high
        rco = 1'b1;
        run_btn = 1'b1;
        tr = 0; nenp = 0; prev = state;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (state != prev) tr++;
            prev = state;
            if (enp) nenp++;
        end
        run_btn = 1'b0;
        rco = 1'b0;
        chk("held_one_transition", tr, 1);
        chk("held_state_run", 32'(state), 1);
        chk("freerun_enp_count", nenp, 4);

        // Asynchronous reset on a step cycle, button held through release
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick(1);
            found = enp;
        end
        chk("reset_step_found", 32'(found), 1);
        run_btn = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_vals", 32'({enp, ent, ldb, clrb, tick_o, is_half, state, done_o}), 32'h060);
        tick(2);
        rst_n = 1'b1;
        tick(10);
        chk("held_at_release_no_event", 32'({state, ent}), 0);
        run_btn = 1'b0;
        tick(2);
        press(3'b001);
        tick(3);
        chk("first_event_after_reset", 32'(state), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
